// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller datapath.
//   tmr_state_e    : countdown timer FSM encodings
//   DEFAULT_CLK_HZ : system clock rate the controller is built for
//   SECONDS_W      : width of every seconds-valued field
//   cnt_width()    : prescaler counter width for a given clock rate
package alarm_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int SECONDS_W      = 4;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'd0,
        TMR_COUNT  = 2'd1,
        TMR_EXPIRE = 2'd2
    } tmr_state_e;

    // Bits needed to hold 0..clk_hz-1. clk_hz is at least 2, so this is
    // never zero.
    function automatic int cnt_width(input int clk_hz);
        return $clog2(clk_hz);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler producing 1 Hz and 0.5 Hz single-cycle enables from the system
// clock. Shared by the countdown timer, fuel pump and siren stages.
// Ports:
//   clock          : system clock, rising edge
//   reset          : synchronous, active-high
//   restart        : realign the divider (cnt and half phase cleared)
//   one_hz_enable  : high for one cycle every CLK_HZ cycles
//   half_hz_enable : high on every second one_hz_enable
module tick_divider
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic one_hz_enable,
    output logic half_hz_enable
);

    localparam int CNT_W = cnt_width(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;
    logic             half_phase;

    // Decoded from the registered count so the enable is glitch-free and
    // lands exactly CLK_HZ edges after a restart.
    assign one_hz_enable  = (cnt == CNT_LAST);
    assign half_hz_enable = one_hz_enable && half_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            half_phase <= 1'b0;
        end else if (restart) begin
            cnt        <= '0;
            half_phase <= 1'b0;
        end else begin
            if (one_hz_enable) begin
                cnt        <= '0;
                half_phase <= ~half_phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown for the alarm controller. A start pulse loads the
// seconds value and realigns the prescaler; the count then drops once per
// 1 Hz enable and a one-cycle expired pulse marks completion.
// Ports:
//   clock          : system clock, rising edge
//   reset          : synchronous, active-high
//   start_timer    : load value and restart prescaler (level, every edge)
//   value          : countdown length in seconds, sampled only on start
//   expired        : one-cycle pulse when the countdown completes
//   one_hz_enable  : 1 Hz single-cycle enable
//   half_hz_enable : 0.5 Hz single-cycle enable
//   value_display  : seconds remaining
module countdown_timer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_timer,
    input  logic [SECONDS_W-1:0] value,
    output logic                 expired,
    output logic                 one_hz_enable,
    output logic                 half_hz_enable,
    output logic [SECONDS_W-1:0] value_display
);

    tmr_state_e           state_q, state_d;
    logic [SECONDS_W-1:0] remaining_q, remaining_d;

    tick_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_divider (
        .clock          (clock),
        .reset          (reset),
        .restart        (start_timer),
        .one_hz_enable  (one_hz_enable),
        .half_hz_enable (half_hz_enable)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= TMR_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Start has priority over everything, including a coincident 1 Hz
    // decrement. COUNT is only ever entered with remaining >= 1, so the
    // decrement cannot wrap.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (start_timer) begin
            remaining_d = value;
            state_d     = (value == '0) ? TMR_EXPIRE : TMR_COUNT;
        end else begin
            unique case (state_q)
                TMR_IDLE: begin
                    remaining_d = '0;
                end
                TMR_COUNT: begin
                    if (one_hz_enable) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == SECONDS_W'(1)) begin
                            state_d = TMR_EXPIRE;
                        end
                    end
                end
                TMR_EXPIRE: begin
                    state_d     = TMR_IDLE;
                    remaining_d = '0;
                end
                default: begin
                    state_d     = TMR_IDLE;
                    remaining_d = '0;
                end
            endcase
        end
    end

    assign expired       = (state_q == TMR_EXPIRE);
    assign value_display = remaining_q;

endmodule
